// File: rtl/button_debounce_multi_pkg.sv
// Shared definitions for the multi-channel button debouncer: FSM state encoding.
package button_debounce_multi_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'b00,
    CHANGE = 2'b01
  } state_t;

endpackage

// File: rtl/button_debounce_multi_channel.sv
// One debounce channel: synchroniser, debounce FSM with counter, press/release pulses
// and optional long-press detection.
module debounce_channel
  import button_debounce_multi_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int COUNTER_LEN      = 19,
  parameter int DEBOUNCE_VALUE   = 5000,
  parameter int FAST_RELEASE     = 0,
  parameter int LONG_LEN         = 24,
  parameter int LONG_PRESS_VALUE = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  input  logic en,
  output logic debounce,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic press_next
);

  localparam logic [COUNTER_LEN-1:0] CNT_LAST = COUNTER_LEN'(DEBOUNCE_VALUE - 1);
  localparam bit FAST = (FAST_RELEASE != 0);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  state_t                 state, state_nxt;
  logic [COUNTER_LEN-1:0] cnt, cnt_nxt;
  logic                   debounce_nxt;
  logic                   release_nxt;

  // synchroniser stage: keeps running even while the channel is disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], btn};
    end
  end

  assign s = sync_p0[SYNC_STAGES-1];

  // debounce stage: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      debounce      <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      debounce      <= debounce_nxt;
      press         <= press_next;
      release_pulse <= release_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (s != debounce && !(FAST && !s)) begin
            state_nxt = CHANGE;
            cnt_nxt   = '0;
          end
        end
        CHANGE: begin
          if (s == debounce) begin
            state_nxt = IDLE;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + COUNTER_LEN'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A disabled channel drops its level silently: no release pulse is produced.
  always_comb begin
    debounce_nxt = debounce;
    press_next   = 1'b0;
    release_nxt  = 1'b0;
    if (!en) begin
      debounce_nxt = 1'b0;
    end else if (state == IDLE && FAST && !s && debounce) begin
      debounce_nxt = 1'b0;
      release_nxt  = 1'b1;
    end else if (state == CHANGE && s != debounce && cnt == CNT_LAST) begin
      debounce_nxt = s;
      press_next   = s;
      release_nxt  = !s;
    end
  end

  // long-press stage: hold counter saturates so the pulse fires once per press
  if (LONG_PRESS_VALUE > 0) begin : g_long
    localparam logic [LONG_LEN-1:0] HOLD_MAX = LONG_LEN'(LONG_PRESS_VALUE);

    logic [LONG_LEN-1:0] hold_cnt;

    function automatic logic [LONG_LEN-1:0] sat_inc(input logic [LONG_LEN-1:0] v);
      return (v == HOLD_MAX) ? v : v + LONG_LEN'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hold_cnt   <= '0;
        long_press <= 1'b0;
      end else if (!en || !debounce) begin
        hold_cnt   <= '0;
        long_press <= 1'b0;
      end else begin
        hold_cnt   <= sat_inc(hold_cnt);
        long_press <= (hold_cnt == HOLD_MAX - LONG_LEN'(1));
      end
    end
  end else begin : g_no_long
    assign long_press = 1'b0;
  end

endmodule

// File: rtl/button_debounce_multi.sv
// N-channel button debouncer: one debounce_channel per input plus a registered any_press.
// The release pulse port is release_pulse because "release" is a reserved word.
module button_debounce_multi
  import button_debounce_multi_pkg::*;
#(
  parameter int CHANNELS         = 4,
  parameter int SYNC_STAGES      = 2,
  parameter int COUNTER_LEN      = 19,
  parameter int DEBOUNCE_VALUE   = 5000,
  parameter int FAST_RELEASE     = 0,
  parameter int LONG_LEN         = 24,
  parameter int LONG_PRESS_VALUE = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] btn,
  input  logic [CHANNELS-1:0] chan_en,
  output logic [CHANNELS-1:0] debounce,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press,
  output logic                any_press
);

  if (CHANNELS < 1) begin : g_bad_channels
    $error("CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_VALUE < 1 || longint'(DEBOUNCE_VALUE) >= (longint'(1) << COUNTER_LEN)) begin : g_bad_deb
    $error("DEBOUNCE_VALUE must be in 1..2^COUNTER_LEN-1");
  end
  if (LONG_PRESS_VALUE < 0 || longint'(LONG_PRESS_VALUE) >= (longint'(1) << LONG_LEN)) begin : g_bad_long
    $error("LONG_PRESS_VALUE must be in 0..2^LONG_LEN-1");
  end

  logic [CHANNELS-1:0] press_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .COUNTER_LEN     (COUNTER_LEN),
      .DEBOUNCE_VALUE  (DEBOUNCE_VALUE),
      .FAST_RELEASE    (FAST_RELEASE),
      .LONG_LEN        (LONG_LEN),
      .LONG_PRESS_VALUE(LONG_PRESS_VALUE)
    ) u_chan (
      .clk          (clk),
      .reset_n      (reset_n),
      .btn          (btn[i]),
      .en           (chan_en[i]),
      .debounce     (debounce[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i]),
      .press_next   (press_next[i])
    );
  end

  // summary stage: built from next-cycle press so it lines up with press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_next;
    end
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Bench for button_debounce_multi: a symmetric and a fast-release instance share stimulus;
// expected pulses are queued as stimulus is driven and matched as the DUTs emit them.
module tb_button_debounce_multi;

  localparam int DV   = 8;
  localparam int LPV  = 20;
  localparam int LAT  = 2 + DV + 1;
  localparam int FLAT = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] btn;
  logic [3:0] chan_en;
  logic [3:0] deb_s, press_s, rel_s, long_s;
  logic [3:0] deb_f, press_f, rel_f, long_f;
  logic       any_s, any_f;

  always #5 clk = ~clk;

  button_debounce_multi #(
    .CHANNELS(4), .SYNC_STAGES(2), .COUNTER_LEN(19), .DEBOUNCE_VALUE(DV),
    .FAST_RELEASE(0), .LONG_LEN(24), .LONG_PRESS_VALUE(LPV)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .btn(btn), .chan_en(chan_en),
    .debounce(deb_s), .press(press_s), .release_pulse(rel_s),
    .long_press(long_s), .any_press(any_s)
  );

  button_debounce_multi #(
    .CHANNELS(4), .SYNC_STAGES(2), .COUNTER_LEN(19), .DEBOUNCE_VALUE(DV),
    .FAST_RELEASE(1), .LONG_LEN(24), .LONG_PRESS_VALUE(0)
  ) dut_f (
    .clk(clk), .reset_n(reset_n), .btn(btn), .chan_en(chan_en),
    .debounce(deb_f), .press(press_f), .release_pulse(rel_f),
    .long_press(long_f), .any_press(any_f)
  );

  // slots: 0 press_s, 1 release_s, 2 long_s, 3 press_f, 4 release_f, 5 long_f
  typedef struct {
    int       cyc;
    int       slot;
    logic [3:0] mask;
  } ev_t;

  ev_t        sb[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  logic [3:0] mon_vec [6];
  ev_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_ev(input int c, input int slot, input logic [3:0] m);
    ev_t e;
    e.cyc  = c;
    e.slot = slot;
    e.mask = m;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    mon_vec[0] = press_s;
    mon_vec[1] = rel_s;
    mon_vec[2] = long_s;
    mon_vec[3] = press_f;
    mon_vec[4] = rel_f;
    mon_vec[5] = long_f;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL missed_pulse slot=%0d got=none want=%h at cyc %0d", sb[0].slot, sb[0].mask, sb[0].cyc);
      void'(sb.pop_front());
    end
    for (int k = 0; k < 6; k++) begin
      if (mon_vec[k] != 4'h0) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pulse slot=%0d got=%h want=none cyc=%0d", k, mon_vec[k], cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.cyc !== cyc || mon_e.slot !== k || mon_e.mask !== mon_vec[k]) begin
            bad++;
            $display("FAIL pulse slot=%0d mask=%h cyc=%0d want slot=%0d mask=%h cyc=%0d",
                     k, mon_vec[k], cyc, mon_e.slot, mon_e.mask, mon_e.cyc);
          end
        end
      end
    end
    total++;
    if (any_s !== (press_s != 4'h0) || any_f !== (press_f != 4'h0)) begin
      bad++;
      $display("FAIL any_press got s=%b f=%b want s=%b f=%b cyc=%0d",
               any_s, any_f, press_s != 4'h0, press_f != 4'h0, cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (sb.size() > 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
      sb.delete();
    end
    step(3);
  endtask

  task automatic test_reset;
    int c;
    reset_n = 1'b0;
    btn     = 4'hF;
    chan_en = 4'hF;
    step(3);
    total++;
    if ({deb_s, press_s, rel_s, long_s, any_s} !== 17'h0) begin
      bad++;
      $display("FAIL reset_s got=%h want=0", {deb_s, press_s, rel_s, long_s, any_s});
    end
    total++;
    if ({deb_f, press_f, rel_f, long_f, any_f} !== 17'h0) begin
      bad++;
      $display("FAIL reset_f got=%h want=0", {deb_f, press_f, rel_f, long_f, any_f});
    end
    reset_n = 1'b1;
    c = cyc;
    push_ev(c + LAT, 0, 4'hF);
    push_ev(c + LAT, 3, 4'hF);
    push_ev(c + LAT + LPV, 2, 4'hF);
    step(LAT - 1);
    total++;
    if (deb_s !== 4'h0 || deb_f !== 4'h0) begin
      bad++;
      $display("FAIL reset_early_deb got s=%h f=%h want 0", deb_s, deb_f);
    end
    step(1);
    total++;
    if (deb_s !== 4'hF || deb_f !== 4'hF) begin
      bad++;
      $display("FAIL reset_deb got s=%h f=%h want F", deb_s, deb_f);
    end
    step(LPV + 3);
    btn = 4'h0;
    c = cyc;
    push_ev(c + FLAT, 4, 4'hF);
    push_ev(c + LAT, 1, 4'hF);
    wait_drain(60);
  endtask

  task automatic test_bounce;
    int c;
    for (int i = 0; i < 5; i++) begin
      btn[0] = 1'b1;
      step(3);
      btn[0] = 1'b0;
      step(3);
    end
    btn[0] = 1'b1;
    c = cyc;
    push_ev(c + LAT, 0, 4'h1);
    push_ev(c + LAT, 3, 4'h1);
    push_ev(c + LAT + LPV, 2, 4'h1);
    step(LAT - 1);
    total++;
    if (deb_s[0] !== 1'b0) begin
      bad++;
      $display("FAIL bounce_early got=%b want=0", deb_s[0]);
    end
    step(1);
    total++;
    if (deb_s[0] !== 1'b1 || deb_f[0] !== 1'b1) begin
      bad++;
      $display("FAIL bounce_deb got s=%b f=%b want 1", deb_s[0], deb_f[0]);
    end
    step(LPV + 2);
    btn[0] = 1'b0;
    c = cyc;
    push_ev(c + FLAT, 4, 4'h1);
    push_ev(c + LAT, 1, 4'h1);
    wait_drain(60);
  endtask

  task automatic test_release;
    int c;
    btn[1] = 1'b1;
    c = cyc;
    push_ev(c + LAT, 0, 4'h2);
    push_ev(c + LAT, 3, 4'h2);
    push_ev(c + LAT + LPV, 2, 4'h2);
    step(LAT + LPV + 2);
    btn[1] = 1'b0;
    c = cyc;
    push_ev(c + FLAT, 4, 4'h2);
    push_ev(c + LAT, 1, 4'h2);
    step(FLAT - 1);
    total++;
    if (deb_f[1] !== 1'b1) begin
      bad++;
      $display("FAIL fast_rel_early got=%b want=1", deb_f[1]);
    end
    step(1);
    total++;
    if (deb_f[1] !== 1'b0 || deb_s[1] !== 1'b1) begin
      bad++;
      $display("FAIL fast_rel got f=%b s=%b want f=0 s=1", deb_f[1], deb_s[1]);
    end
    step(LAT - FLAT - 1);
    total++;
    if (deb_s[1] !== 1'b1) begin
      bad++;
      $display("FAIL sym_rel_early got=%b want=1", deb_s[1]);
    end
    step(1);
    total++;
    if (deb_s[1] !== 1'b0) begin
      bad++;
      $display("FAIL sym_rel got=%b want=0", deb_s[1]);
    end
    wait_drain(60);
  endtask

  task automatic test_long_press;
    int c;
    btn[2] = 1'b1;
    c = cyc;
    push_ev(c + LAT, 0, 4'h4);
    push_ev(c + LAT, 3, 4'h4);
    push_ev(c + LAT + LPV, 2, 4'h4);
    step(50);
    btn[2] = 1'b0;
    c = cyc;
    push_ev(c + FLAT, 4, 4'h4);
    push_ev(c + LAT, 1, 4'h4);
    step(20);
    btn[2] = 1'b1;
    c = cyc;
    push_ev(c + LAT, 0, 4'h4);
    push_ev(c + LAT, 3, 4'h4);
    push_ev(c + LAT + LPV, 2, 4'h4);
    step(LAT + LPV - 1);
    total++;
    if (long_s[2] !== 1'b0) begin
      bad++;
      $display("FAIL long_early got=%b want=0", long_s[2]);
    end
    step(4);
    btn[2] = 1'b0;
    c = cyc;
    push_ev(c + FLAT, 4, 4'h4);
    push_ev(c + LAT, 1, 4'h4);
    wait_drain(60);
  endtask

  task automatic test_simultaneous;
    int c;
    btn = 4'b0101;
    c = cyc;
    push_ev(c + LAT, 0, 4'h5);
    push_ev(c + LAT, 3, 4'h5);
    push_ev(c + LAT + LPV, 2, 4'h5);
    step(LAT + LPV + 2);
    btn = 4'h0;
    c = cyc;
    push_ev(c + FLAT, 4, 4'h5);
    push_ev(c + LAT, 1, 4'h5);
    wait_drain(60);
  endtask

  task automatic test_chan_en;
    int c;
    btn[3] = 1'b1;
    c = cyc;
    push_ev(c + LAT, 0, 4'h8);
    push_ev(c + LAT, 3, 4'h8);
    step(LAT + 4);
    total++;
    if (deb_s[3] !== 1'b1) begin
      bad++;
      $display("FAIL en_pre got=%b want=1", deb_s[3]);
    end
    chan_en[3] = 1'b0;
    step(1);
    total++;
    if (deb_s[3] !== 1'b0 || deb_f[3] !== 1'b0) begin
      bad++;
      $display("FAIL en_off got s=%b f=%b want 0", deb_s[3], deb_f[3]);
    end
    step(5);
    chan_en[3] = 1'b1;
    c = cyc;
    push_ev(c + DV + 1, 0, 4'h8);
    push_ev(c + DV + 1, 3, 4'h8);
    push_ev(c + DV + 1 + LPV, 2, 4'h8);
    step(DV);
    total++;
    if (deb_s[3] !== 1'b0) begin
      bad++;
      $display("FAIL en_re_early got=%b want=0", deb_s[3]);
    end
    step(1);
    total++;
    if (deb_s[3] !== 1'b1 || deb_f[3] !== 1'b1) begin
      bad++;
      $display("FAIL en_re got s=%b f=%b want 1", deb_s[3], deb_f[3]);
    end
    step(LPV + 2);
    btn[3] = 1'b0;
    c = cyc;
    push_ev(c + FLAT, 4, 4'h8);
    push_ev(c + LAT, 1, 4'h8);
    wait_drain(60);
  endtask

  task automatic test_reset_mid;
    int c;
    btn[0] = 1'b1;
    c = cyc;
    push_ev(c + LAT, 0, 4'h1);
    push_ev(c + LAT, 3, 4'h1);
    step(LAT + 2);
    btn[1] = 1'b1;
    step(7);
    reset_n = 1'b0;
    #1;
    total++;
    if ({deb_s, press_s, rel_s, long_s, any_s} !== 17'h0 ||
        {deb_f, press_f, rel_f, long_f, any_f} !== 17'h0) begin
      bad++;
      $display("FAIL reset_mid got s=%h f=%h want 0", {deb_s, press_s, rel_s, long_s, any_s},
               {deb_f, press_f, rel_f, long_f, any_f});
    end
    step(3);
    reset_n = 1'b1;
    c = cyc;
    push_ev(c + LAT, 0, 4'h3);
    push_ev(c + LAT, 3, 4'h3);
    push_ev(c + LAT + LPV, 2, 4'h3);
    step(LAT - 1);
    total++;
    if (deb_s !== 4'h0 || deb_f !== 4'h0) begin
      bad++;
      $display("FAIL reset_mid_early got s=%h f=%h want 0", deb_s, deb_f);
    end
    step(1);
    total++;
    if (deb_s !== 4'h3 || deb_f !== 4'h3) begin
      bad++;
      $display("FAIL reset_mid_deb got s=%h f=%h want 3", deb_s, deb_f);
    end
    step(LPV + 2);
    btn = 4'h0;
    c = cyc;
    push_ev(c + FLAT, 4, 4'h3);
    push_ev(c + LAT, 1, 4'h3);
    wait_drain(60);
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_release();
    test_long_press();
    test_simultaneous();
    test_chan_en();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
